// File: rtl/mem_init_seq_pkg.sv
// Shared pattern-mode and FSM-state encodings for the S-memory initialiser.
package mem_init_pkg;

  typedef enum logic [1:0] {
    MODE_IDENTITY = 2'd0,
    MODE_FILL     = 2'd1,
    MODE_DESCEND  = 2'd2
  } mode_e;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_WRITE = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

endpackage

// File: rtl/mem_init_seq_if.sv
// Write port between the initialiser and the S-memory; the memory side may stall a write.
interface mem_init_seq_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_stall;

  modport master (output wr_en, output wr_addr, output wr_data, input wr_stall);
  modport slave  (input wr_en, input wr_addr, input wr_data, output wr_stall);

endinterface

// File: rtl/mem_init_seq_addr_counter.sv
// Address counter with synchronous clear and a terminal-count flag at DEPTH-1.
module init_addr_counter #(
  parameter int W     = 9,
  parameter int DEPTH = 256
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         tc
);

  localparam logic [W-1:0] LAST = W'(DEPTH - 1);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

  assign tc = (count == LAST);

endmodule

// File: rtl/mem_init_seq.sv
// Sweeps DEPTH RAM words with an identity, fill or descending pattern, then holds done until acked.
// Outputs decode registered state only; a stalled write holds address and data.
module mem_init_seq
  import mem_init_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] fill_value,
  input  logic              abort,
  input  logic              done_ack,
  output logic              busy,
  output logic              done,
  mem_init_seq_if.master    mem
);

  localparam int CNT_W = ADDR_W + 1;

  state_t            state;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] fill_q;
  logic [CNT_W-1:0]  count;
  logic              tc;
  logic              in_write;
  logic              accept;
  logic              cnt_clr;
  logic              cnt_en;
  logic [DATA_W-1:0] pat;

  assign in_write = (state == ST_WRITE);
  // Abort beats a same-edge accept, so that write is never counted.
  assign accept   = in_write && !mem.wr_stall && !abort;
  assign cnt_clr  = ((state == ST_IDLE) && start) || (accept && tc);
  assign cnt_en   = accept && !tc;

  init_addr_counter #(
    .W     (CNT_W),
    .DEPTH (DEPTH)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (count),
    .tc    (tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      mode_q <= '0;
      fill_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state  <= ST_WRITE;
            mode_q <= mode;
            fill_q <= fill_value;
          end
        end
        ST_WRITE: begin
          if (abort) begin
            state <= ST_IDLE;
          end else if (accept && tc) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (done_ack) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Modular subtraction in DATA_W bits yields the truncated DEPTH-1-count directly.
  always_comb begin
    pat = fill_q;
    case (mode_q)
      MODE_IDENTITY: pat = DATA_W'(count);
      MODE_DESCEND:  pat = DATA_W'(DEPTH - 1) - DATA_W'(count);
      default:       pat = fill_q;
    endcase
  end

  assign mem.wr_en   = in_write;
  assign mem.wr_addr = in_write ? count[ADDR_W-1:0] : '0;
  assign mem.wr_data = in_write ? pat : '0;
  assign busy        = in_write;
  assign done        = (state == ST_DONE);

endmodule

// File: tb/tb_mem_init_seq.sv
// Bench for mem_init_seq: a 256-deep and a 16-deep instance checked against a write scoreboard.
module tb_mem_init_seq;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  logic       clk = 1'b0;
  logic       reset, start, abort, done_ack, busy, done;
  logic [1:0] mode;
  logic [7:0] fill_value;
  logic       s_start, s_abort, s_ack, s_busy, s_done;
  logic [1:0] s_mode;
  logic [7:0] s_fill;

  wr_t exp_q[$];
  int  n_cmp  = 0;
  int  n_fail = 0;

  always #5 clk = ~clk;

  mem_init_seq_if #(.ADDR_W(8), .DATA_W(8)) wr ();
  mem_init_seq_if #(.ADDR_W(4), .DATA_W(8)) wr_s ();

  mem_init_seq #(.ADDR_W(8), .DATA_W(8), .DEPTH(256)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .fill_value(fill_value),
    .abort(abort), .done_ack(done_ack), .busy(busy), .done(done), .mem(wr)
  );

  mem_init_seq #(.ADDR_W(4), .DATA_W(8), .DEPTH(16)) dut_s (
    .clk(clk), .reset(reset), .start(s_start), .mode(s_mode), .fill_value(s_fill),
    .abort(s_abort), .done_ack(s_ack), .busy(s_busy), .done(s_done), .mem(wr_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // kind 0: data=addr, 1: data=fill, 2: data=255-addr
  task automatic push_run(input int kind, input logic [7:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      wr_t e;
      e.addr = 8'(i);
      e.data = (kind == 0) ? 8'(i) : (kind == 1) ? f : 8'(255 - i);
      exp_q.push_back(e);
    end
  endtask

  task automatic do_start(input logic [1:0] m, input logic [7:0] f);
    mode = m;
    fill_value = f;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Consumes the scoreboard as the big DUT presents writes; may stall, pulse start, or kill the run.
  task automatic sb_run(input string tag, input int stall_addr, input int stall_n,
                        input int kill_addr, input bit kill_rst, input int start_addr,
                        output int en_cycles, output bit got_done);
    int  stalls;
    bit  ended;
    wr_t e;
    stalls = 0; en_cycles = 0; got_done = 1'b0; ended = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (done) begin got_done = 1'b1; ended = 1'b1; break; end
      if (!wr.wr_en) begin ended = 1'b1; break; end
      en_cycles++;
      start = (int'(wr.wr_addr) == start_addr);
      if (int'(wr.wr_addr) == kill_addr) begin
        wr.wr_stall = 1'b0;
        if (kill_rst) reset = 1'b1; else abort = 1'b1;
        tick();
        reset = 1'b0; abort = 1'b0; start = 1'b0;
        ended = 1'b1;
        break;
      end
      if (exp_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL %s extra_write: addr=%0d presented, scoreboard empty", tag, wr.wr_addr);
        ended = 1'b1;
        break;
      end
      e = exp_q[0];
      n_cmp++;
      if (wr.wr_addr !== e.addr || wr.wr_data !== e.data) begin
        n_fail++;
        $display("FAIL %s write: got addr=%0d data=%02h, expected addr=%0d data=%02h",
                 tag, wr.wr_addr, wr.wr_data, e.addr, e.data);
      end
      if (int'(wr.wr_addr) == stall_addr && stalls < stall_n) begin
        wr.wr_stall = 1'b1;
        stalls++;
      end else begin
        wr.wr_stall = 1'b0;
        void'(exp_q.pop_front());
      end
      tick();
    end
    wr.wr_stall = 1'b0;
    start = 1'b0;
    if (!ended) begin
      n_cmp++; n_fail++;
      $display("FAIL %s timeout: run did not finish within 2000 cycles", tag);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 0; abort = 0; done_ack = 0; mode = 0; fill_value = 0;
    s_start = 0; s_abort = 0; s_ack = 0; s_mode = 0; s_fill = 0;
    wr.wr_stall = 1'b0; wr_s.wr_stall = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    n_cmp++; if (wr.wr_en !== 1'b0)   begin n_fail++; $display("FAIL reset_wr_en: got %b, expected 0", wr.wr_en); end
    n_cmp++; if (wr.wr_addr !== 8'd0) begin n_fail++; $display("FAIL reset_wr_addr: got %0d, expected 0", wr.wr_addr); end
    n_cmp++; if (wr.wr_data !== 8'd0) begin n_fail++; $display("FAIL reset_wr_data: got %02h, expected 00", wr.wr_data); end
    n_cmp++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    n_cmp++; if (done !== 1'b0)       begin n_fail++; $display("FAIL reset_done: got %b, expected 0", done); end
    n_cmp++; if (s_busy !== 1'b0 || s_done !== 1'b0 || wr_s.wr_en !== 1'b0) begin
      n_fail++; $display("FAIL reset_small: busy=%b done=%b wr_en=%b, expected all 0", s_busy, s_done, wr_s.wr_en);
    end
  endtask

  task automatic test_identity();
    int en; bit gd;
    push_run(0, 8'h00, 256);
    do_start(2'd0, 8'h00);
    sb_run("identity", -1, 0, -1, 1'b0, -1, en, gd);
    n_cmp++; if (en != 256) begin n_fail++; $display("FAIL identity_len: got %0d wr_en cycles, expected 256", en); end
    n_cmp++; if (!gd) begin n_fail++; $display("FAIL identity_done: done=%b after last accept, expected 1", done); end
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL identity_left: %0d writes missing, expected 0", exp_q.size()); end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if (done !== 1'b1 || wr.wr_en !== 1'b0) begin
        n_fail++; $display("FAIL done_hold: cycle %0d done=%b wr_en=%b, expected 1/0", i, done, wr.wr_en);
      end
    end
    done_ack = 1'b1;
    tick();
    done_ack = 1'b0;
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL ack_idle: done=%b busy=%b, expected 0/0", done, busy); end
    tick();
    n_cmp++; if (wr.wr_en !== 1'b0) begin n_fail++; $display("FAIL idle_no_run: wr_en=%b, expected 0", wr.wr_en); end
    exp_q.delete();
  endtask

  task automatic test_fill_stall();
    int en; bit gd;
    push_run(1, 8'hA5, 256);
    do_start(2'd1, 8'hA5);
    sb_run("fill_stall", 17, 3, -1, 1'b0, -1, en, gd);
    n_cmp++; if (en != 259) begin n_fail++; $display("FAIL fill_len: got %0d wr_en cycles, expected 259", en); end
    n_cmp++; if (!gd || exp_q.size() != 0) begin
      n_fail++; $display("FAIL fill_end: done=%b remaining=%0d, expected 1/0", gd, exp_q.size());
    end
    done_ack = 1'b1; tick(); done_ack = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_abort();
    int en; bit gd;
    push_run(0, 8'h00, 100);
    do_start(2'd0, 8'h00);
    sb_run("abort", -1, 0, 100, 1'b0, -1, en, gd);
    n_cmp++; if (busy !== 1'b0 || wr.wr_en !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL abort_idle: busy=%b wr_en=%b done=%b, expected 0/0/0", busy, wr.wr_en, done);
    end
    n_cmp++; if (en != 101 || gd || exp_q.size() != 0) begin
      n_fail++; $display("FAIL abort_run: cycles=%0d done=%b remaining=%0d, expected 101/0/0", en, gd, exp_q.size());
    end
    for (int i = 0; i < 5; i++) tick();
    n_cmp++; if (done !== 1'b0 || wr.wr_en !== 1'b0) begin
      n_fail++; $display("FAIL abort_quiet: done=%b wr_en=%b, expected 0/0", done, wr.wr_en);
    end
    exp_q.delete();
    push_run(0, 8'h00, 256);
    do_start(2'd0, 8'h00);
    sb_run("abort_restart", -1, 0, -1, 1'b0, -1, en, gd);
    n_cmp++; if (en != 256 || !gd || exp_q.size() != 0) begin
      n_fail++; $display("FAIL abort_restart: cycles=%0d done=%b remaining=%0d, expected 256/1/0", en, gd, exp_q.size());
    end
    done_ack = 1'b1; tick(); done_ack = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_start_ignored();
    int en; bit gd; bit saw_wr;
    push_run(0, 8'h00, 256);
    do_start(2'd0, 8'h00);
    sb_run("start_in_write", -1, 0, -1, 1'b0, 40, en, gd);
    n_cmp++; if (en != 256 || !gd || exp_q.size() != 0) begin
      n_fail++; $display("FAIL start_in_write: cycles=%0d done=%b remaining=%0d, expected 256/1/0", en, gd, exp_q.size());
    end
    start = 1'b1; tick(); start = 1'b0;
    n_cmp++; if (done !== 1'b1 || wr.wr_en !== 1'b0) begin
      n_fail++; $display("FAIL start_in_done: done=%b wr_en=%b, expected 1/0", done, wr.wr_en);
    end
    start = 1'b1; done_ack = 1'b1; tick(); start = 1'b0; done_ack = 1'b0;
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL start_with_ack: done=%b busy=%b, expected 0/0", done, busy);
    end
    saw_wr = 1'b0;
    for (int i = 0; i < 4; i++) begin tick(); if (wr.wr_en) saw_wr = 1'b1; end
    n_cmp++; if (saw_wr) begin n_fail++; $display("FAIL no_second_run: wr_en seen=%b, expected 0", saw_wr); end
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    int en; bit gd;
    push_run(2, 8'h00, 50);
    do_start(2'd2, 8'h00);
    sb_run("reset_mid", -1, 0, 50, 1'b1, -1, en, gd);
    n_cmp++; if (wr.wr_en !== 1'b0 || wr.wr_addr !== 8'd0 || wr.wr_data !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_outs: wr_en=%b addr=%0d data=%02h busy=%b done=%b, expected all 0",
                         wr.wr_en, wr.wr_addr, wr.wr_data, busy, done);
    end
    n_cmp++; if (exp_q.size() != 0 || en != 51) begin
      n_fail++; $display("FAIL reset_mid_run: cycles=%0d remaining=%0d, expected 51/0", en, exp_q.size());
    end
    exp_q.delete();
    tick();
    push_run(0, 8'h00, 256);
    do_start(2'd0, 8'h00);
    sb_run("reset_restart", -1, 0, -1, 1'b0, -1, en, gd);
    n_cmp++; if (en != 256 || !gd || exp_q.size() != 0) begin
      n_fail++; $display("FAIL reset_restart: cycles=%0d done=%b remaining=%0d, expected 256/1/0", en, gd, exp_q.size());
    end
    done_ack = 1'b1; tick(); done_ack = 1'b0;
    exp_q.delete();
  endtask

  // DEPTH=16: descending 15..0, then reserved mode 3 acting as a fill.
  task automatic test_small_depth();
    for (int k = 0; k < 2; k++) begin
      int  en; bit gd; bit ended;
      wr_t e;
      en = 0; gd = 1'b0; ended = 1'b0;
      for (int i = 0; i < 16; i++) begin
        e.addr = 8'(i);
        e.data = (k == 0) ? 8'(15 - i) : 8'h3C;
        exp_q.push_back(e);
      end
      s_mode = (k == 0) ? 2'd2 : 2'd3;
      s_fill = 8'h3C;
      s_start = 1'b1; tick(); s_start = 1'b0;
      for (int c = 0; c < 200; c++) begin
        if (s_done) begin gd = 1'b1; ended = 1'b1; break; end
        if (!wr_s.wr_en || exp_q.size() == 0) begin ended = 1'b1; break; end
        en++;
        e = exp_q.pop_front();
        n_cmp++;
        if ({4'b0, wr_s.wr_addr} !== e.addr || wr_s.wr_data !== e.data) begin
          n_fail++; $display("FAIL small%0d write: got addr=%0d data=%02h, expected addr=%0d data=%02h",
                             k, wr_s.wr_addr, wr_s.wr_data, e.addr, e.data);
        end
        tick();
      end
      n_cmp++; if (!ended || en != 16 || !gd || exp_q.size() != 0 || s_busy !== 1'b0) begin
        n_fail++; $display("FAIL small%0d_run: cycles=%0d done=%b remaining=%0d busy=%b, expected 16/1/0/0",
                           k, en, gd, exp_q.size(), s_busy);
      end
      s_ack = 1'b1; tick(); s_ack = 1'b0;
      tick();
      n_cmp++; if (s_done !== 1'b0 || wr_s.wr_en !== 1'b0) begin
        n_fail++; $display("FAIL small%0d_ack: done=%b wr_en=%b, expected 0/0", k, s_done, wr_s.wr_en);
      end
      exp_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_fill_stall();
    test_abort();
    test_start_ignored();
    test_reset_mid();
    test_small_depth();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
